gate2_sweep_checker: RTL and testbench
======================================

Name: gate2_sweep_checker

Overview:
- Sequential stimulus generator and response checker for any 2-input logic gate in the library (AND/OR/NAND/NOR/XOR/XNOR).
- Drives the gate's a/b inputs through every input combination and samples the gate's y output.
- Compares each y sample against the expected truth table and reports pass/fail plus a mismatch count.
- Sits on the driving side of a gate under test. Used in self-checking gate benches and in on-board demo wrappers.

Parameters:
- SETTLE_CYCLES, 1: cycles each vector is held before y is sampled. Legal values ≥1.
- PASSES, 1: number of full 4-vector sweeps per run. Legal values ≥1.
- ERR_W, 8: width of err_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  run request. Sampled only in IDLE.
- func_sel  input  3  expected function: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 reserved.
- dut_y  input  1  output of the gate under test (combinational).
- dut_a  output  1  gate input a, registered.
- dut_b  output  1  gate input b, registered.
- busy  output  1  high from the first DRIVE cycle until DONE is entered.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  high when the last run finished with zero mismatches. Held until the next start.
- err_count  output  ERR_W  mismatches in the last or current run. Saturates at all-ones.
- first_fail_vec  output  2  {a,b} of the first mismatch in the run. Value 00 when no mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset: state IDLE, vec=00, sweep=0, settle counter=0. All outputs 0.
- rst has priority over every other input in every state. Asserting rst mid-run aborts the run, and all outputs are 0 on the following cycle.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start=1, latch func_sel into an internal register, set vec=00, sweep=0, and clear err_count, pass and first_fail_vec.
  - If the latched code is valid, go to DRIVE; if reserved, go to DONE.
  - start=0 keeps IDLE; all outputs hold.
- DRIVE:
  - dut_a=vec[1] and dut_b=vec[0], registered on entry. busy=1.
  - Stay for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: one cycle.
  - Compute expected = f(latched func, vec[1], vec[0]).
  - On dut_y != expected: err_count increments (saturating). If this is the first mismatch of the run, first_fail_vec=vec.
  - If vec=11 and sweep=PASSES-1, go to DONE.
  - Otherwise vec increments, wrapping 11→00; sweep increments on wrap. Go to DRIVE.
- DONE: one cycle.
  - done=1 and busy=0.
  - pass=1 only when the latched code is valid and err_count=0; otherwise pass=0.
  - Go to IDLE.
- Latency, valid code: done is high in the cycle after edge k+4·PASSES·(SETTLE_CYCLES+1), where k is the edge that sampled start. With defaults this is edge k+8.
- Latency, reserved code: done is high in the cycle after edge k+1. pass=0, err_count=0.
- func_sel changes and start pulses while not in IDLE are ignored.
- If start is held high continuously, a new run begins on the edge after DONE→IDLE.
- dut_a and dut_b keep their last driven value in DONE and IDLE. Reset returns them to 0.

Optional Feature:
- Macro GATE_CHK_STOP_ON_FAIL_EN.
- Defined: on the first mismatch, SAMPLE goes directly to DONE. err_count=1 and first_fail_vec is recorded. The remaining vectors and sweeps are skipped.
- Undefined: the full sweep always completes and err_count counts all mismatches.

Test Plan:
- func_sel=010, DUT model y=~(a&b), defaults, start pulse → dut_a/dut_b step through 00,01,10,11; done at edge k+8; pass=1, err_count=0, first_fail_vec=00.
- func_sel=010, DUT model y=a&b → pass=0, err_count=4, first_fail_vec=00. With GATE_CHK_STOP_ON_FAIL_EN: done at edge k+2, err_count=1.
- func_sel=100 (XOR), DUT correct except y=1 at ab=11, PASSES=2, SETTLE_CYCLES=3 → done at edge k+32; err_count=2, first_fail_vec=11, pass=0.
- rst asserted in DRIVE at vec=01 → next cycle all outputs 0 and state IDLE. A subsequent start with a correct DUT gives pass=1.
- func_sel=110 → done at edge k+1, pass=0, err_count=0, dut_a/dut_b unchanged.
- start held high for 20 cycles with func_sel toggled every cycle → runs use only the func_sel value sampled in IDLE. done pulses at edges k+8 and k+18 (second run starts at edge k+10 in IDLE). ERR_W=2 with 8 mismatches → err_count saturates at 3.

Source files
------------

// File: rtl/gate2_sweep_checker.sv
// Sweeps all four {a,b} vectors into a 2-input gate and checks its y output against the selected truth table.
// Optional build macro GATE_CHK_STOP_ON_FAIL_EN: when defined, a run ends at its first mismatch.
module gate2_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func_sel,
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SW_W = (PASSES > 1) ? $clog2(PASSES) : 1;

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        func_q;
  logic [1:0]        vec;
  logic [SW_W-1:0]   sweep;
  logic [SC_W-1:0]   settle_cnt;
  logic              rsv_pend;
  logic              fail_seen;

  logic              expected;
  logic              mismatch;
  logic              last_vec;
  logic              settle_done;
  logic              stop_run;
  logic [ERR_W-1:0]  err_inc;
  logic [ERR_W-1:0]  err_after;
  logic [1:0]        vec_nxt;

  function automatic logic func_valid(input logic [2:0] f);
    return (f <= 3'b101);
  endfunction

  function automatic logic gate_eval(input logic [2:0] f, input logic a, input logic b);
    logic r;
    case (f)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~(a & b);
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    expected    = gate_eval(func_q, vec[1], vec[0]);
    mismatch    = (dut_y != expected);
    last_vec    = (vec == 2'b11) && (sweep == SW_W'(PASSES - 1));
    settle_done = (settle_cnt == SC_W'(SETTLE_CYCLES - 1));
    stop_run    = last_vec || (STOP_ON_FAIL && mismatch);
    err_inc     = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + ERR_W'(1);
    err_after   = mismatch ? err_inc : err_count;
    vec_nxt     = vec + 2'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // A reserved code waits one cycle in IDLE before reporting, keeping its latency at two edges.
        if (rsv_pend)   state_nxt = DONE;
        else if (start) state_nxt = func_valid(func_sel) ? DRIVE : IDLE;
      end
      DRIVE:   if (settle_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = stop_run ? DONE : DRIVE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == DRIVE) || (state == SAMPLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      func_q         <= '0;
      vec            <= '0;
      sweep          <= '0;
      settle_cnt     <= '0;
      rsv_pend       <= 1'b0;
      fail_seen      <= 1'b0;
      dut_a          <= 1'b0;
      dut_b          <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rsv_pend) begin
            rsv_pend <= 1'b0;
          end else if (start) begin
            func_q         <= func_sel;
            vec            <= '0;
            sweep          <= '0;
            settle_cnt     <= '0;
            fail_seen      <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            if (func_valid(func_sel)) begin
              dut_a <= 1'b0;
              dut_b <= 1'b0;
            end else begin
              rsv_pend <= 1'b1;
            end
          end
        end
        DRIVE: begin
          if (!settle_done) settle_cnt <= settle_cnt + SC_W'(1);
        end
        SAMPLE: begin
          err_count <= err_after;
          if (mismatch && !fail_seen) begin
            fail_seen      <= 1'b1;
            first_fail_vec <= vec;
          end
          if (stop_run) begin
            pass <= (err_after == '0);
          end else begin
            vec        <= vec_nxt;
            settle_cnt <= '0;
            dut_a      <= vec_nxt[1];
            dut_b      <= vec_nxt[0];
            if (vec == 2'b11) sweep <= sweep + SW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate2_sweep_checker.sv
// Scoreboard bench for gate2_sweep_checker: three instances with different parameters, each facing a modelled gate.
module tb_gate2_sweep_checker;

  typedef struct {
    int         lat;
    logic [7:0] err;
    logic [1:0] ffv;
    logic       pass;
    logic [1:0] ab;
  } exp_t;

  localparam int NI = 3;
  localparam int SET_P [NI] = '{1, 3, 1};
  localparam int PAS_P [NI] = '{1, 2, 2};
  localparam int ERW_P [NI] = '{8, 8, 2};

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [NI];
  logic [2:0] func_v  [NI];
  logic [2:0] gfunc_v [NI];
  logic [3:0] flip_v  [NI];
  logic       y_v     [NI];
  logic       a_v     [NI];
  logic       b_v     [NI];
  logic       busy_v  [NI];
  logic       done_v  [NI];
  logic       pass_v  [NI];
  logic [7:0] err_v   [NI];
  logic [1:0] ffv_v   [NI];
  logic [7:0] err0, err1;
  logic [1:0] err2;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb [$];
  logic [1:0] seen_ab [$];
  logic [1:0] last_ab [NI];

  always #5 clk = ~clk;

  // Truth tables indexed by {a,b}.
  function automatic logic [3:0] tbl(input logic [2:0] f);
    case (f)
      3'b000:  return 4'b1000;
      3'b001:  return 4'b1110;
      3'b010:  return 4'b0111;
      3'b011:  return 4'b0001;
      3'b100:  return 4'b0110;
      3'b101:  return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic gate_model(input logic [2:0] f, input logic [3:0] flip, input logic a, input logic b);
    logic [3:0] t;
    t = tbl(f) ^ flip;
    return t[{a, b}];
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) y_v[i] = gate_model(gfunc_v[i], flip_v[i], a_v[i], b_v[i]);
  end

  assign err_v[0] = err0;
  assign err_v[1] = err1;
  assign err_v[2] = {6'b0, err2};

  gate2_sweep_checker u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .func_sel(func_v[0]), .dut_y(y_v[0]),
    .dut_a(a_v[0]), .dut_b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err0), .first_fail_vec(ffv_v[0]));

  gate2_sweep_checker #(.SETTLE_CYCLES(3), .PASSES(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .func_sel(func_v[1]), .dut_y(y_v[1]),
    .dut_a(a_v[1]), .dut_b(b_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err1), .first_fail_vec(ffv_v[1]));

  gate2_sweep_checker #(.PASSES(2), .ERR_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .func_sel(func_v[2]), .dut_y(y_v[2]),
    .dut_a(a_v[2]), .dut_b(b_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_count(err2), .first_fail_vec(ffv_v[2]));

  function automatic exp_t predict(input int idx, input logic [2:0] sel, input logic [2:0] gf, input logic [3:0] flip);
    exp_t e;
    logic [3:0] mask;
    int step, maxv;
    bit stopped;
    mask  = (tbl(gf) ^ flip) ^ tbl(sel);
    maxv  = (1 << ERW_P[idx]) - 1;
    e.err = 8'd0; e.ffv = 2'b00; e.ab = 2'b11;
    e.lat = 4 * PAS_P[idx] * (SET_P[idx] + 1);
    step = 0; stopped = 1'b0;
    if (sel > 3'b101) begin
      e.lat = 1; e.pass = 1'b0; e.ab = last_ab[idx];
      return e;
    end
    for (int p = 0; p < PAS_P[idx]; p++) begin
      for (int v = 0; v < 4; v++) begin
        if (!stopped) begin
          step++;
          if (mask[v]) begin
            if (e.err == 8'd0) e.ffv = 2'(v);
            if (int'(e.err) < maxv) e.err = e.err + 8'd1;
            if (STOP_EN) begin
              stopped = 1'b1;
              e.lat = step * (SET_P[idx] + 1);
              e.ab  = 2'(v);
            end
          end
        end
      end
    end
    e.pass = (e.err == 8'd0);
    return e;
  endfunction

  task automatic compare_done(input int idx, input int lat, input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: done observed at %0d with no expected run queued", tag, lat);
      return;
    end
    e = sb.pop_front();
    n_cmp++;
    if (lat !== e.lat) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e.lat); end
    n_cmp++;
    if (err_v[idx] !== e.err) begin n_bad++; $display("FAIL %s err_count: got %0d want %0d", tag, err_v[idx], e.err); end
    n_cmp++;
    if (ffv_v[idx] !== e.ffv) begin n_bad++; $display("FAIL %s first_fail_vec: got %b want %b", tag, ffv_v[idx], e.ffv); end
    n_cmp++;
    if (pass_v[idx] !== e.pass) begin n_bad++; $display("FAIL %s pass: got %b want %b", tag, pass_v[idx], e.pass); end
    n_cmp++;
    if ({a_v[idx], b_v[idx]} !== e.ab) begin n_bad++; $display("FAIL %s dut_ab: got %b%b want %b", tag, a_v[idx], b_v[idx], e.ab); end
    n_cmp++;
    if (busy_v[idx] !== 1'b0) begin n_bad++; $display("FAIL %s busy at done: got %b want 0", tag, busy_v[idx]); end
    last_ab[idx] = e.ab;
  endtask

  task automatic run(input int idx, input logic [2:0] sel, input logic [2:0] gf, input logic [3:0] flip, input string tag);
    int n;
    bit got;
    sb.push_back(predict(idx, sel, gf, flip));
    gfunc_v[idx] = gf;
    flip_v[idx]  = flip;
    @(negedge clk);
    func_v[idx]  = sel;
    start_v[idx] = 1'b1;
    @(posedge clk);
    n = 0; got = 1'b0;
    seen_ab.delete();
    while (!got && n < 300) begin
      @(negedge clk);
      start_v[idx] = 1'b0;
      func_v[idx]  = 3'b111;
      if (busy_v[idx] && (seen_ab.size() == 0 || seen_ab[$] != {a_v[idx], b_v[idx]}))
        seen_ab.push_back({a_v[idx], b_v[idx]});
      if (done_v[idx]) got = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no done after %0d edges", tag, n);
      void'(sb.pop_front());
    end else begin
      compare_done(idx, n, tag);
    end
    @(negedge clk);
  endtask

  task automatic check_idle_zero(input int idx, input string tag);
    n_cmp++;
    if ({busy_v[idx], done_v[idx], pass_v[idx], err_v[idx], ffv_v[idx], a_v[idx], b_v[idx]} !== '0) begin
      n_bad++;
      $display("FAIL %s: busy=%b done=%b pass=%b err=%0d ffv=%b a=%b b=%b want all 0", tag,
               busy_v[idx], done_v[idx], pass_v[idx], err_v[idx], ffv_v[idx], a_v[idx], b_v[idx]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle_zero(i, "reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check_idle_zero(i, "idle_hold");
    for (int i = 0; i < NI; i++) last_ab[i] = 2'b00;
  endtask

  task automatic test_correct_sweep();
    logic [1:0] want [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    run(0, 3'b010, 3'b010, 4'b0000, "nand_ok");
    n_cmp++;
    if (seen_ab.size() != 4) begin
      n_bad++; $display("FAIL nand_ok vector count: got %0d want 4", seen_ab.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (seen_ab[i] !== want[i]) begin n_bad++; $display("FAIL nand_ok vector %0d: got %b want %b", i, seen_ab[i], want[i]); end
      end
    end
  endtask

  task automatic test_wrong_gate();
    run(0, 3'b010, 3'b000, 4'b0000, "nand_vs_and");
  endtask

  task automatic test_reserved();
    run(0, 3'b110, 3'b010, 4'b0000, "reserved110");
  endtask

  task automatic test_multi_pass();
    run(1, 3'b100, 3'b100, 4'b1000, "xor_p2_s3");
  endtask

  task automatic test_saturation();
    run(2, 3'b000, 3'b000, 4'b1111, "sat_w2");
  endtask

  task automatic test_mid_reset();
    int n;
    gfunc_v[0] = 3'b010; flip_v[0] = 4'b0000;
    @(negedge clk);
    func_v[0] = 3'b010; start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    n = 0;
    while (!(busy_v[0] && a_v[0] == 1'b0 && b_v[0] == 1'b1) && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 50) begin n_bad++; $display("FAIL mid_reset: vector 01 never driven"); end
    rst = 1'b1;
    @(negedge clk);
    check_idle_zero(0, "mid_reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero(0, "mid_reset_idle");
    for (int i = 0; i < NI; i++) last_ab[i] = 2'b00;
    run(0, 3'b010, 3'b010, 4'b0000, "after_reset");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int ndone;
    gfunc_v[0] = 3'b010; flip_v[0] = 4'b0000;
    e = predict(0, 3'b010, 3'b010, 4'b0000);
    sb.push_back(e);
    e.lat = 2 * e.lat + 2;
    sb.push_back(e);
    ndone = 0;
    @(negedge clk);
    func_v[0] = 3'b010; start_v[0] = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 26; j++) begin
      @(negedge clk);
      start_v[0] = (j < 19);
      func_v[0]  = ((j + 1) % 2 == 0) ? 3'b010 : 3'b000;
      if (done_v[0]) begin
        ndone++;
        compare_done(0, j, "back_to_back");
      end
      @(posedge clk);
    end
    start_v[0] = 1'b0;
    n_cmp++;
    if (ndone != 2) begin n_bad++; $display("FAIL back_to_back done pulses: got %0d want 2", ndone); end
    while (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; func_v[i] = 3'b000; gfunc_v[i] = 3'b000; flip_v[i] = 4'b0000;
    end
    test_reset();
    test_correct_sweep();
    test_wrong_gate();
    test_reserved();
    test_multi_pass();
    test_saturation();
    test_mid_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
